// File: rtl/ariane_pkg.sv
// Shadow-register frame layout shared by the save controller and the restorer.
package ariane_pkg;

    localparam int unsigned NUM_SHADOW_SAVES   = 16;
    localparam int unsigned SHADOW_SLOT_MEPC   = 0;
    localparam int unsigned SHADOW_SLOT_MCAUSE = 2;
    // x2 is not stored in the frame; it is recomputed as the frame end address
    localparam int unsigned SHADOW_REG_SP      = 2;

endpackage

// File: rtl/config_pkg.sv
// Core configuration subset used by the shadow-register blocks.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64};

endpackage

// File: rtl/shadow_register_restorer.sv
// Pops one shadow-register frame from memory on a nested mret, reloading
// x1..x15 through a dedicated RF port and mepc/mcause into the CSR file.
module shadow_register_restorer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg          = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NUM_SHADOW_SAVES = ariane_pkg::NUM_SHADOW_SAVES,
    parameter int unsigned           ADDR_WIDTH       = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    restore_i,
    input  logic [CVA6Cfg.XLEN-1:0] frame_sp_i,
    input  logic [4:0]              save_level_i,
    output logic                    busy_o,
    output logic                    load_req_o,
    output logic [CVA6Cfg.XLEN-1:0] load_addr_o,
    input  logic                    load_gnt_i,
    input  logic                    load_rvalid_i,
    input  logic [CVA6Cfg.XLEN-1:0] load_rdata_i,
    output logic                    rf_we_o,
    output logic [ADDR_WIDTH-1:0]   rf_waddr_o,
    output logic [CVA6Cfg.XLEN-1:0] rf_wdata_o,
    output logic                    csr_mepc_we_o,
    output logic                    csr_mcause_we_o,
    output logic [CVA6Cfg.XLEN-1:0] csr_wdata_o,
    output logic                    level_dec_o,
    output logic                    done_o,
    output logic                    error_o
);

    localparam int unsigned XLEN        = CVA6Cfg.XLEN;
    localparam int unsigned WORD_BYTES  = XLEN / 8;
    localparam int unsigned WORD_SHIFT  = $clog2(WORD_BYTES);
    localparam int unsigned SLOT_W      = $clog2(NUM_SHADOW_SAVES);
    localparam int unsigned FRAME_BYTES = NUM_SHADOW_SAVES * WORD_BYTES;

    localparam logic [SLOT_W-1:0] SLOT_MEPC   = SLOT_W'(ariane_pkg::SHADOW_SLOT_MEPC);
    localparam logic [SLOT_W-1:0] SLOT_MCAUSE = SLOT_W'(ariane_pkg::SHADOW_SLOT_MCAUSE);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(NUM_SHADOW_SAVES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        SP,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q,  slot_d;
    logic [XLEN-1:0]    base_q,  base_d;
    logic               error_q, error_d;
    logic [XLEN-1:0]    slot_addr;

    // Address arithmetic wraps modulo 2^XLEN by construction
    assign slot_addr = base_q + (XLEN'(slot_q) << WORD_SHIFT);
    assign error_o   = error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            slot_q  <= '0;
            base_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            base_q  <= base_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        base_d          = base_q;
        error_d         = 1'b0;
        busy_o          = 1'b0;
        load_req_o      = 1'b0;
        load_addr_o     = '0;
        rf_we_o         = 1'b0;
        rf_waddr_o      = '0;
        rf_wdata_o      = '0;
        csr_mepc_we_o   = 1'b0;
        csr_mcause_we_o = 1'b0;
        csr_wdata_o     = '0;
        level_dec_o     = 1'b0;
        done_o          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (restore_i) begin
                    if (save_level_i != 5'd0) begin
                        base_d  = frame_sp_i;
                        slot_d  = '0;
                        state_d = REQ;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            REQ: begin
                busy_o      = 1'b1;
                load_req_o  = 1'b1;
                load_addr_o = slot_addr;
                if (load_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                busy_o = 1'b1;
                if (load_rvalid_i) begin
                    if (slot_q == SLOT_MEPC) begin
                        csr_mepc_we_o = 1'b1;
                        csr_wdata_o   = load_rdata_i;
                    end else if (slot_q == SLOT_MCAUSE) begin
                        csr_mcause_we_o = 1'b1;
                        csr_wdata_o     = load_rdata_i;
                    end else begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = ADDR_WIDTH'(slot_q);
                        rf_wdata_o = load_rdata_i;
                    end
                    slot_d  = slot_q + SLOT_W'(1);
                    state_d = (slot_q == SLOT_LAST) ? SP : REQ;
                end
            end
            SP: begin
                // Restored sp is the address just past the popped frame
                busy_o     = 1'b1;
                rf_we_o    = 1'b1;
                rf_waddr_o = ADDR_WIDTH'(ariane_pkg::SHADOW_REG_SP);
                rf_wdata_o = base_q + XLEN'(FRAME_BYTES);
                state_d    = DONE;
            end
            DONE: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                level_dec_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shadow_register_restorer.sv
// Scoreboard bench for shadow_register_restorer: randomized frames, a memory
// responder with per-slot latencies, and a monitor checking every strobe.
module tb_shadow_register_restorer;

    localparam int K_RF = 0, K_MEPC = 1, K_MCAUSE = 2, K_DONE = 3, K_ERR = 4;

    typedef struct {
        int          kind;
        logic [63:0] reg_idx;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    logic        clk, rst_ni;
    logic        restore_i;
    logic [63:0] frame_sp_i;
    logic [4:0]  save_level_i;
    logic        busy_o, load_req_o;
    logic [63:0] load_addr_o;
    logic        load_gnt_i, load_rvalid_i;
    logic [63:0] load_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic        csr_mepc_we_o, csr_mcause_we_o;
    logic [63:0] csr_wdata_o;
    logic        level_dec_o, done_o, error_o;

    shadow_register_restorer dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .restore_i       (restore_i),
        .frame_sp_i      (frame_sp_i),
        .save_level_i    (save_level_i),
        .busy_o          (busy_o),
        .load_req_o      (load_req_o),
        .load_addr_o     (load_addr_o),
        .load_gnt_i      (load_gnt_i),
        .load_rvalid_i   (load_rvalid_i),
        .load_rdata_i    (load_rdata_i),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .csr_mepc_we_o   (csr_mepc_we_o),
        .csr_mcause_we_o (csr_mcause_we_o),
        .csr_wdata_o     (csr_wdata_o),
        .level_dec_o     (level_dec_o),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    ev_t         ev_q[$];
    logic [63:0] addr_q[$];

    // Memory model: word k of the current frame reads as mem_seed + k
    logic [63:0] cur_base = '0;
    logic [63:0] mem_seed = '0;
    int          gnt_d[16];
    int          rv_d[16];
    int          spur_slot = -1;

    // Responder state
    int          resp_k = 0;
    bit          in_req = 0;
    bit          pend_rv = 0;
    int          g_wait = 0;
    int          r_wait = 0;
    logic [63:0] pend_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        n_checks++;
        n_fails++;
        $display("FAIL %s: actual=0x%0h required=none (cycle %0d)", name, act, cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   64'(busy_o), 64'd0);
        chk({tag, "_req"},    64'(load_req_o), 64'd0);
        chk({tag, "_addr"},   load_addr_o, 64'd0);
        chk({tag, "_rfwe"},   64'(rf_we_o), 64'd0);
        chk({tag, "_rfwa"},   64'(rf_waddr_o), 64'd0);
        chk({tag, "_rfwd"},   rf_wdata_o, 64'd0);
        chk({tag, "_csrwe"},  64'({csr_mepc_we_o, csr_mcause_we_o}), 64'd0);
        chk({tag, "_csrwd"},  csr_wdata_o, 64'd0);
        chk({tag, "_pulses"}, 64'({level_dec_o, done_o, error_o}), 64'd0);
    endtask

    // Memory responder: grant/rvalid with per-slot latency, driven at negedge
    initial begin
        load_gnt_i = 1'b0; load_rvalid_i = 1'b0; load_rdata_i = '0;
        forever begin
            @(negedge clk);
            load_gnt_i    = 1'b0;
            load_rvalid_i = 1'b0;
            load_rdata_i  = '0;
            if (!rst_ni) begin
                in_req = 0; pend_rv = 0;
            end else if (pend_rv) begin
                if (r_wait == 0) begin
                    load_rvalid_i = 1'b1;
                    load_rdata_i  = mem_seed + ((pend_addr - cur_base) >> 3);
                    pend_rv = 0;
                end else r_wait--;
            end else if (load_req_o) begin
                if (!in_req) begin
                    in_req = 1;
                    g_wait = gnt_d[resp_k];
                end
                if (resp_k == spur_slot) begin
                    load_rvalid_i = 1'b1;
                    load_rdata_i  = 64'hDEAD_BEEF_0BAD_F00D;
                end
                if (g_wait == 0) begin
                    load_gnt_i = 1'b1;
                    pend_rv    = 1;
                    pend_addr  = load_addr_o;
                    r_wait     = rv_d[resp_k];
                    in_req     = 0;
                    resp_k++;
                end else g_wait--;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or load
    initial begin
        bit          prev_wait = 0;
        logic [63:0] prev_addr = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_ni) begin
                prev_wait = 0;
                continue;
            end
            if (prev_wait) begin
                chk("req_held", 64'(load_req_o), 64'd1);
                chk("addr_held", load_addr_o, prev_addr);
            end
            if (load_req_o) begin
                if (addr_q.size() == 0) flag("unexpected_load", load_addr_o);
                else begin
                    chk("load_addr", load_addr_o, addr_q[0]);
                    if (load_gnt_i) void'(addr_q.pop_front());
                end
            end
            prev_wait = load_req_o && !load_gnt_i;
            prev_addr = load_addr_o;
            begin
                int   ns;
                ev_t  o;
                ns = 32'(rf_we_o) + 32'(csr_mepc_we_o) + 32'(csr_mcause_we_o) + 32'(done_o) + 32'(error_o);
                if (ns > 1) flag("strobes_exclusive", 64'(ns));
                if (done_o || level_dec_o) chk("level_dec_with_done", 64'(level_dec_o), 64'(done_o));
                if (ns != 0) begin
                    o.reg_idx = '0; o.data = '0; o.cyc = cyc;
                    if (rf_we_o) begin o.kind = K_RF; o.reg_idx = 64'(rf_waddr_o); o.data = rf_wdata_o; end
                    else if (csr_mepc_we_o) begin o.kind = K_MEPC; o.data = csr_wdata_o; end
                    else if (csr_mcause_we_o) begin o.kind = K_MCAUSE; o.data = csr_wdata_o; end
                    else if (done_o) o.kind = K_DONE;
                    else o.kind = K_ERR;
                    if (ev_q.size() == 0) flag("unexpected_strobe_kind", 64'(o.kind));
                    else begin
                        ev_t e;
                        e = ev_q.pop_front();
                        chk("strobe_kind", 64'(o.kind), 64'(e.kind));
                        if (e.kind == K_RF) chk("rf_waddr", o.reg_idx, e.reg_idx);
                        if (e.kind <= K_MCAUSE) chk("wdata", o.data, e.data);
                        if (e.cyc >= 0) chk("strobe_cycle", 64'(o.cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    // Issue a restore; the expected frame contents are pushed before the pulse
    task automatic start_restore(input logic [63:0] base, input logic [63:0] seed, input logic [4:0] lvl);
        int t, sum;
        ev_t e;
        @(negedge clk);
        cur_base = base; mem_seed = seed;
        resp_k = 0; in_req = 0; pend_rv = 0;
        t = cyc;
        if (lvl == 5'd0) begin
            e = '{K_ERR, 64'd0, 64'd0, t + 1};
            ev_q.push_back(e);
        end else begin
            sum = 0;
            for (int k = 0; k < 16; k++) begin
                addr_q.push_back(base + 64'(k) * 64'd8);
                sum += gnt_d[k] + rv_d[k] + 2;
                if (k == 0)      e = '{K_MEPC, 64'd0, seed, -1};
                else if (k == 2) e = '{K_MCAUSE, 64'd0, seed + 64'd2, -1};
                else             e = '{K_RF, 64'(k), seed + 64'(k), -1};
                ev_q.push_back(e);
            end
            e = '{K_RF, 64'd2, base + 64'd128, t + 1 + sum};
            ev_q.push_back(e);
            e = '{K_DONE, 64'd0, 64'd0, t + 2 + sum};
            ev_q.push_back(e);
        end
        restore_i = 1'b1; frame_sp_i = base; save_level_i = lvl;
        @(negedge clk);
        restore_i = 1'b0; frame_sp_i = {$urandom, $urandom}; save_level_i = 5'($urandom);
        #2;
        chk("busy_at_T1", 64'(busy_o), 64'(lvl != 5'd0));
        chk("req_at_T1", 64'(load_req_o), 64'(lvl != 5'd0));
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #3;
            if (ev_q.size() == 0 && addr_q.size() == 0 && !busy_o) begin ok = 1; break; end
        end
        if (!ok) begin
            flag({tag, "_timeout_pending"}, 64'(ev_q.size()));
            ev_q.delete(); addr_q.delete();
        end
    endtask

    task automatic zero_delays();
        for (int k = 0; k < 16; k++) begin gnt_d[k] = 0; rv_d[k] = 0; end
        spur_slot = -1;
    endtask

    initial begin
        restore_i = 1'b0; frame_sp_i = '0; save_level_i = '0;
        rst_ni = 1'b0;
        zero_delays();
        repeat (3) @(negedge clk);
        #2 chk_all_zero("reset");
        @(negedge clk); rst_ni = 1'b1;

        // Zero-wait frame at 0x8000 with word k = 0x100+k
        start_restore(64'h8000, 64'h100, 5'd1);
        wait_idle("basic");

        // Grant stalled 3 cycles on slot 5
        gnt_d[5] = 3;
        start_restore(64'h8000, 64'h100, 5'd1);
        wait_idle("gnt_stall");
        zero_delays();

        // Illegal restore at level 0
        start_restore(64'h1234_0000, 64'h0, 5'd0);
        chk("err_busy", 64'(busy_o), 64'd0);
        wait_idle("illegal");

        // Reset while waiting for slot 7 data
        rv_d[7] = 6;
        start_restore(64'h9000, 64'h700, 5'd2);
        begin
            bit hit = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (resp_k == 8 && pend_rv) begin hit = 1; break; end
            end
            if (!hit) flag("reach_slot7_resp", 64'(resp_k));
        end
        #3 rst_ni = 1'b0;
        load_rvalid_i = 1'b0; load_gnt_i = 1'b0;
        #1 chk_all_zero("async_reset");
        ev_q.delete(); addr_q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #2 chk("idle_after_reset", 64'(busy_o), 64'd0);
        zero_delays();
        start_restore(64'hA000, 64'h5000, 5'd1);
        wait_idle("after_reset");

        // Base near the top of the address space wraps
        start_restore(64'hFFFF_FFFF_FFFF_FFC0, 64'h2000, 5'd3);
        wait_idle("wrap");

        // Restore pulse while busy plus a spurious rvalid during REQ
        gnt_d[4] = 2; spur_slot = 4;
        start_restore(64'hB000, 64'h3000, 5'd1);
        repeat (8) @(negedge clk);
        restore_i = 1'b1; save_level_i = 5'd0; frame_sp_i = 64'h4444;
        @(negedge clk);
        restore_i = 1'b0;
        wait_idle("busy_poke");
        zero_delays();

        // Randomized frames and latencies
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 16; k++) begin
                gnt_d[k] = 32'($urandom_range(0, 3));
                rv_d[k]  = 32'($urandom_range(0, 3));
            end
            spur_slot = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : -1;
            start_restore({$urandom, $urandom} & ~64'h7, {$urandom, $urandom}, 5'($urandom_range(0, 4)));
            wait_idle("random");
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shadow_register_restorer.md
# shadow_register_restorer

Restore path for the shadow-register exception mechanism. On an `mret` that leaves a nested trap level, the block pops one saved frame from the memory stack. It reloads the integer registers through a dedicated register-file write port and returns `mepc`/`mcause` to the CSR file. It sits beside the shadow-register save controller, between the issue stage (trigger/stall), the register file, the CSR regfile and a data-cache load port, and performs the exact inverse of the save frame layout.

## Interface
Parameters:
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration; `XLEN` sets data/address width.
- `NUM_SHADOW_SAVES`, 16: words per frame.
- `ADDR_WIDTH`, 5: register address width.

Ports:
- `clk_i`  in  1  clock; the block uses one clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `restore_i`  in  1  pulse from issue: restore the top frame.
- `frame_sp_i`  in  XLEN  current x2, which is the frame base; sampled on acceptance.
- `save_level_i`  in  5  current nesting level from the save controller.
- `busy_o`  out  1  restore in progress; issue stalls.
- `load_req_o`  out  1  load request to the D$ port.
- `load_addr_o`  out  XLEN  load address.
- `load_gnt_i`  in  1  request accepted.
- `load_rvalid_i`  in  1  load data valid.
- `load_rdata_i`  in  XLEN  load data.
- `rf_we_o`  out  1  register-file write enable.
- `rf_waddr_o`  out  5  register-file write address.
- `rf_wdata_o`  out  XLEN  register-file write data.
- `csr_mepc_we_o`  out  1  write `mepc`.
- `csr_mcause_we_o`  out  1  write `mcause`.
- `csr_wdata_o`  out  XLEN  CSR data.
- `level_dec_o`  out  1  pulse: decrement the save level.
- `done_o`  out  1  pulse: restore complete.
- `error_o`  out  1  pulse: illegal restore request.

## Operation
- Frame layout, word size `XLEN/8` bytes, slot `k` at `base + k*XLEN/8`:
  - slot 0 holds `mepc`.
  - slot 1 holds x1.
  - slot 2 holds `mcause`, because x2 is not stored.
  - slots 3..15 hold x3..x15.
- FSM states: IDLE, REQ, RESP, SP, DONE.
- IDLE:
  - `restore_i` with `save_level_i != 0`: latch `base = frame_sp_i`, set slot = 0, go to REQ.
  - `restore_i` with `save_level_i == 0`: pulse `error_o` next cycle and stay in IDLE.
- REQ:
  - `load_req_o = 1` and `load_addr_o = base + slot*XLEN/8`; both are held stable until `load_gnt_i`.
  - On grant, go to RESP. One load is outstanding at most.
- RESP:
  - Wait for `load_rvalid_i`.
  - In the rvalid cycle the data is applied combinationally:
    - slot 0 asserts `csr_mepc_we_o`.
    - slot 2 asserts `csr_mcause_we_o`.
    - other slots assert `rf_we_o` with `rf_waddr_o = slot`.
  - Then slot increments. If the slot was 15, go to SP; otherwise go to REQ.
- SP: `rf_we_o = 1`, `rf_waddr_o = 2`, `rf_wdata_o = base + NUM_SHADOW_SAVES*XLEN/8`; go to DONE.
- DONE: pulse `done_o` and `level_dec_o` for one cycle; return to IDLE.
- `busy_o` is 1 in every state except IDLE.
- `restore_i` outside IDLE is ignored (no error); issue must not raise it while `busy_o` is high.
- Address arithmetic is modulo 2^XLEN; a base near the top wraps silently.
- `load_rvalid_i` outside RESP is ignored.
- Register writes never target x0.

## Timing
- Reset values: every output is 0, the FSM is IDLE, and slot/base are 0.
- Reset asserted mid-restore aborts immediately. The frame is left partially restored and the level is not decremented; the core reboots anyway.
- `restore_i` at cycle T gives `busy_o` and `load_req_o` high at T+1.
- Minimum 2 cycles per slot (grant in the REQ cycle, rvalid the next cycle), so with zero wait-states `done_o` rises at T+1+32+1 = T+34.
- Grant and rvalid latency are unbounded; request address and enable stay stable while waiting.
- All write strobes are single-cycle and mutually exclusive per cycle.
- `error_o` fires at T+1 for an illegal request.

## Structure
- Shared package (`ariane_pkg`): frame slot constants `SHADOW_SLOT_MEPC=0` and `SHADOW_SLOT_MCAUSE=2`, and the `NUM_SHADOW_SAVES` default. The save controller uses the same constants, so the two blocks share one layout definition.
- FSM state enum: local to the module.
- No sub-module; the address generator (base plus shifted slot) is inline.

## Test plan
- XLEN=64, base=0x8000, level=1, zero-wait memory with word k = 0x100+k:
  - loads go to 0x8000, 0x8008, … 0x8078.
  - `mepc` = 0x100 and `mcause` = 0x102.
  - x1 = 0x101, x3..x15 = 0x103..0x10F, then x2 = 0x8080.
  - `done_o` and `level_dec_o` pulse once, at T+34.
- `load_gnt_i` delayed 3 cycles on slot 5: `load_addr_o` holds 0x8028 and `load_req_o` stays high the whole time; final state matches the previous scenario.
- `restore_i` with `save_level_i=0`: `error_o` pulses at T+1; `busy_o` stays 0 and no load is issued.
- `rst_ni` dropped while in RESP for slot 7: all outputs are 0 asynchronously; after release the FSM is IDLE and a new restore starts again at slot 0.
- base=0xFFFF_FFFF_FFFF_FFC0: slot 8 address wraps to 0x0; x2 restored to 0x40.
- `restore_i` pulsed while busy, plus a spurious `load_rvalid_i` in REQ: both are ignored, with no extra writes and no error.
